// File: rtl/aes_ctr_block_gen_if.sv
// Counter-block stream from the CTR generator to the AES core (valid/ready).
interface aes_ctr_block_gen_if;
  logic         blk_valid_o;
  logic         blk_ready_i;
  logic [127:0] blk_data_o;
  logic         blk_last_o;

  modport master (
    output blk_valid_o,
    output blk_data_o,
    output blk_last_o,
    input  blk_ready_i
  );

  modport slave (
    input  blk_valid_o,
    input  blk_data_o,
    input  blk_last_o,
    output blk_ready_i
  );
endinterface

// File: rtl/aes_ctr_block_gen.sv
// CTR-mode counter-block generator: emits {nonce, counter} blocks to the AES core,
// one per accepted transfer, with abort, wrap detection and a done pulse.
module aes_ctr_block_gen #(
  parameter int unsigned NONCE_W = 96,
  parameter int unsigned CTR_W   = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [NONCE_W-1:0]   nonce_i,
  input  logic [CTR_W-1:0]     ctr_init_i,
  input  logic [CNT_W-1:0]     nblocks_i,
  input  logic                 abort_i,
  aes_ctr_block_gen_if.master  blk,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 wrap_o
);

  localparam int unsigned BLK_W = 128;

  generate
    if (NONCE_W + CTR_W != BLK_W) begin : g_width_check
      $error("aes_ctr_block_gen: NONCE_W + CTR_W must equal 128");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [CTR_W-1:0]   ctr_q,   ctr_d;
  logic [CNT_W-1:0]   rem_q,   rem_d;
  logic               wrap_q,  wrap_d;
  logic               valid_q, valid_d;
  logic               last_q,  last_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic               xfer;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, datapath and next-output decode; outputs are registered below
  always_comb begin
    state_d = state_q;
    nonce_d = nonce_q;
    ctr_d   = ctr_q;
    rem_d   = rem_q;
    wrap_d  = wrap_q;
    xfer    = (state_q == ST_RUN) && blk.blk_ready_i;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          nonce_d = nonce_i;
          ctr_d   = ctr_init_i;
          rem_d   = nblocks_i;
          wrap_d  = 1'b0;
          state_d = (nblocks_i != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (xfer) begin
          ctr_d = ctr_q + CTR_W'(1);
          rem_d = rem_q - CNT_W'(1);
          if (ctr_q == '1) begin
            wrap_d = 1'b1;
          end
          if (rem_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
        // Abort beats completion, but a transfer in the same cycle still counts
        if (abort_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    valid_d = (state_d == ST_RUN);
    last_d  = (state_d == ST_RUN) && (rem_d == CNT_W'(1));
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  // Captured fields and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      nonce_q <= '0;
      ctr_q   <= '0;
      rem_q   <= '0;
      wrap_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      nonce_q <= nonce_d;
      ctr_q   <= ctr_d;
      rem_q   <= rem_d;
      wrap_q  <= wrap_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign blk.blk_valid_o = valid_q;
  assign blk.blk_data_o  = {nonce_q, ctr_q};
  assign blk.blk_last_o  = last_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign wrap_o          = wrap_q;

endmodule

// File: tb/tb_aes_ctr_block_gen.sv
// Randomized bench for aes_ctr_block_gen against a message-level reference model.
module tb_aes_ctr_block_gen;

  localparam int unsigned NONCE_W = 96;
  localparam int unsigned CTR_W   = 32;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned MAX_CYC = 200;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               start_i;
  logic [NONCE_W-1:0] nonce_i;
  logic [CTR_W-1:0]   ctr_init_i;
  logic [CNT_W-1:0]   nblocks_i;
  logic               abort_i;
  logic               busy_o;
  logic               done_o;
  logic               wrap_o;

  int n_checks = 0;
  int n_fails  = 0;

  aes_ctr_block_gen_if blk ();

  aes_ctr_block_gen #(
    .NONCE_W (NONCE_W),
    .CTR_W   (CTR_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .nonce_i    (nonce_i),
    .ctr_init_i (ctr_init_i),
    .nblocks_i  (nblocks_i),
    .abort_i    (abort_i),
    .blk        (blk),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .wrap_o     (wrap_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: block k of a message is {nonce, (ctr0 + k) mod 2^32}; the wrap flag is
  // set once the all-ones counter value has been transferred, i.e. ctr0 + k >= 2^32.
  function automatic logic [127:0] model_blk(input logic [95:0] nonce, input logic [31:0] ctr0, input int k);
    logic [31:0] c;
    c = ctr0 + 32'(k);
    return {nonce, c};
  endfunction

  function automatic logic model_wrap(input logic [31:0] ctr0, input int k);
    logic [32:0] s;
    s = {1'b0, ctr0} + 33'(k);
    return s[32];
  endfunction

  task automatic check_outputs(input string tag, input logic valid, input logic [127:0] data,
                               input logic last, input logic busy, input logic done, input logic wrap);
    check_eq({tag, ".valid"}, 128'(blk.blk_valid_o), 128'(valid));
    check_eq({tag, ".data"},  blk.blk_data_o, data);
    check_eq({tag, ".last"},  128'(blk.blk_last_o), 128'(last));
    check_eq({tag, ".busy"},  128'(busy_o), 128'(busy));
    check_eq({tag, ".done"},  128'(done_o), 128'(done));
    check_eq({tag, ".wrap"},  128'(wrap_o), 128'(wrap));
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_msg(input string tag, input logic [95:0] nonce, input logic [31:0] ctr0,
                         input int n, input int ready_pct, input int abort_at);
    int   i;
    int   cycles;
    logic aborted;
    i       = 0;
    cycles  = 0;
    aborted = 1'b0;
    start_i    = 1'b1;
    nonce_i    = nonce;
    ctr_init_i = ctr0;
    nblocks_i  = CNT_W'(n);
    abort_i    = 1'($urandom_range(0, 1));
    @(posedge clk_i);

    while (i < n && cycles < int'(MAX_CYC)) begin
      @(negedge clk_i);
      cycles++;
      check_outputs({tag, ".run"}, 1'b1, model_blk(nonce, ctr0, i), (i == n - 1),
                    1'b1, 1'b0, model_wrap(ctr0, i));
      start_i          = ($urandom_range(0, 3) == 0);
      nonce_i          = {$urandom, $urandom, $urandom};
      ctr_init_i       = $urandom;
      nblocks_i        = CNT_W'($urandom);
      blk.blk_ready_i  = ($urandom_range(1, 100) <= ready_pct);
      abort_i          = (i == abort_at);
      @(posedge clk_i);
      if (blk.blk_ready_i) i++;
      if (abort_i) begin
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted && i < n) check_eq({tag, ".timeout"}, 128'(i), 128'(n));

    @(negedge clk_i);
    start_i         = 1'b0;
    blk.blk_ready_i = 1'($urandom_range(0, 1));
    if (aborted) begin
      check_outputs({tag, ".abort"}, 1'b0, model_blk(nonce, ctr0, i), 1'b0,
                    1'b0, 1'b0, model_wrap(ctr0, i));
      abort_i = 1'b0;
      return;
    end
    check_outputs({tag, ".done"}, 1'b0, model_blk(nonce, ctr0, n), 1'b0,
                  1'b1, 1'b1, model_wrap(ctr0, n));
    if (ready_pct >= 100) check_eq({tag, ".cycles"}, 128'(cycles), 128'(n));
    abort_i = 1'($urandom_range(0, 1));
    @(negedge clk_i);
    check_outputs({tag, ".idle"}, 1'b0, model_blk(nonce, ctr0, n), 1'b0,
                  1'b0, 1'b0, model_wrap(ctr0, n));
    abort_i = 1'b0;
  endtask

  // Reset while stalled in RUN with the wrap flag already set.
  task automatic reset_mid_run();
    logic [95:0] nonce;
    nonce      = {$urandom, $urandom, $urandom};
    start_i    = 1'b1;
    nonce_i    = nonce;
    ctr_init_i = 32'hFFFF_FFFF;
    nblocks_i  = 16'd5;
    abort_i    = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    check_outputs("rst_run.first", 1'b1, {nonce, 32'hFFFF_FFFF}, 1'b0, 1'b1, 1'b0, 1'b0);
    blk.blk_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check_outputs("rst_run.wrapped", 1'b1, {nonce, 32'h0}, 1'b0, 1'b1, 1'b0, 1'b1);
    blk.blk_ready_i = 1'b0;
    start_i         = 1'b1;
    nonce_i         = ~nonce;
    @(posedge clk_i);
    @(negedge clk_i);
    check_outputs("rst_run.stall", 1'b1, {nonce, 32'h0}, 1'b0, 1'b1, 1'b0, 1'b1);
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check_outputs("rst_run.reset", 1'b0, 128'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_i   = 1'b0;
    start_i = 1'b0;
  endtask

  initial begin
    logic [95:0] nonce_a5;
    logic [31:0] c0;
    int          n;
    int          ab;
    nonce_a5        = {12{8'hA5}};
    rst_i           = 1'b1;
    start_i         = 1'b1;
    abort_i         = 1'b1;
    nonce_i         = '1;
    ctr_init_i      = '1;
    nblocks_i       = '1;
    blk.blk_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check_outputs("reset", 1'b0, 128'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_i   = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;

    run_msg("basic3", nonce_a5, 32'h0, 3, 100, -1);
    run_msg("bp2", {$urandom, $urandom, $urandom}, $urandom, 2, 30, -1);
    run_msg("wrap4", nonce_a5, 32'hFFFF_FFFE, 4, 100, -1);
    run_msg("wrapclr", {$urandom, $urandom, $urandom}, 32'h10, 1, 100, -1);
    run_msg("zero", {$urandom, $urandom, $urandom}, $urandom, 0, 100, -1);
    run_msg("abort", nonce_a5, 32'h100, 5, 100, 2);
    run_msg("after_abort", {$urandom, $urandom, $urandom}, $urandom, 3, 100, -1);
    reset_mid_run();

    for (int m = 0; m < 40; m++) begin
      c0 = ($urandom_range(0, 2) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 5))) : $urandom;
      n  = $urandom_range(0, 8);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : -1;
      run_msg("rand", {$urandom, $urandom, $urandom}, c0, n, $urandom_range(30, 100), ab);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
